// File: rtl/spi_rx_sync.sv
// SPI receive slave in the clk domain: synchronises sclk/mosi/cs_n, deserialises
// DATA_BITS-wide words and presents them through a valid/ready output register.
module spi_rx_sync #(
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs_n,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_BITS - 1);
  localparam logic SclkIdle = (CPOL != 0);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;
  logic mosi_s1_q, mosi_s2_q;

  logic [0:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  logic                 sclk_rise, sclk_fall, sample, cs_fall, cs_rise, word_done;
  logic [DATA_BITS-1:0] shift_in;

  // Synchronisers reset to idle levels so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= SclkIdle;
      sclk_s2_q <= SclkIdle;
      sclk_h_q  <= SclkIdle;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_h_q    <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      cs_s1_q   <= cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
      mosi_s1_q <= mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sclk_rise = sclk_s2_q & ~sclk_h_q;
  assign sclk_fall = ~sclk_s2_q & sclk_h_q;
  assign sample    = (CPOL == CPHA) ? sclk_rise : sclk_fall;
  assign cs_fall   = ~cs_s2_q & cs_h_q;
  assign cs_rise   = cs_s2_q & ~cs_h_q;
  assign shift_in  = (LSB_FIRST != 0) ? {mosi_s2_q, shift_q[DATA_BITS-1:1]}
                                      : {shift_q[DATA_BITS-2:0], mosi_s2_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    out_d     = out_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    word_done = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StActive;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StActive: begin
        // cs_n deassertion wins over a coincident sample edge.
        if (cs_rise) begin
          state_d = StIdle;
          fe_d    = (cnt_q != '0);
          cnt_d   = '0;
          shift_d = '0;
        end else if (sample) begin
          shift_d = shift_in;
          if (cnt_q == LastCnt) begin
            cnt_d     = '0;
            word_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (word_done) begin
      if (!valid_q || out_ready) begin
        out_d   = shift_in;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;

endmodule

// File: tb/tb_spi_rx_sync.sv
// Drives one SPI bit stream into all four clock modes at once and checks each
// instance against a word-level model of valid/ready, overrun and frame errors.
module tb_spi_rx_sync;

  localparam int W    = 16;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_base = 1'b0;
  logic mosi = 1'b0;
  logic cs_n = 1'b1;
  logic out_ready = 1'b0;

  logic [NDUT-1:0] sclk_w, valid_w, fe_w, ov_w;
  logic [W-1:0]    out_w [NDUT];

  always #5 clk = ~clk;

  // Instance g runs mode g: CPOL = g/2, CPHA = g%2; only mode 0 is LSB first.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign sclk_w[g] = (g >= 2) ? ~sclk_base : sclk_base;
    spi_rx_sync #(
      .DATA_BITS(W),
      .CPOL     (g / 2),
      .CPHA     (g % 2),
      .LSB_FIRST((g == 0) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk     (sclk_w[g]),
      .mosi     (mosi),
      .cs_n     (cs_n),
      .out      (out_w[g]),
      .out_valid(valid_w[g]),
      .out_ready(out_ready),
      .frame_err(fe_w[g]),
      .overrun  (ov_w[g])
    );
  end

  int           fe_cnt [NDUT];
  int           ov_cnt [NDUT];
  logic [W-1:0] acc_q  [NDUT][$];

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (fe_w[d]) fe_cnt[d]++;
      if (ov_w[d]) ov_cnt[d]++;
      if (valid_w[d] && out_ready) acc_q[d].push_back(out_w[d]);
    end
  end

  logic [W-1:0] exp_out [NDUT];
  bit           exp_valid [NDUT];
  int           exp_fe [NDUT];
  int           exp_ov [NDUT];
  logic [W-1:0] exp_acc [NDUT][$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // tx[k] is the k-th bit on the wire; MSB-first receivers see it reversed.
  function automatic logic [W-1:0] dut_word(input int d, input logic [W-1:0] tx);
    return (d == 0) ? tx : rev(tx);
  endfunction

  task automatic model_word(input logic [W-1:0] tx);
    for (int d = 0; d < NDUT; d++) begin
      logic [W-1:0] w;
      w = dut_word(d, tx);
      if (out_ready) begin
        exp_out[d] = w;
        exp_acc[d].push_back(w);
      end else if (!exp_valid[d]) begin
        exp_out[d]   = w;
        exp_valid[d] = 1'b1;
      end else begin
        exp_ov[d]++;
      end
    end
  endtask

  task automatic model_frame(input logic [63:0] tx, input int nbits);
    for (int k = 0; k < nbits / W; k++) model_word(tx[k*W +: W]);
    if (nbits % W != 0) for (int d = 0; d < NDUT; d++) exp_fe[d]++;
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      exp_out[d]   = '0;
      exp_valid[d] = 1'b0;
    end
  endtask

  task automatic set_ready(input bit r);
    @(posedge clk);
    #2 out_ready = r;
    if (r) begin
      for (int d = 0; d < NDUT; d++) begin
        if (exp_valid[d]) begin
          exp_acc[d].push_back(exp_out[d]);
          exp_valid[d] = 1'b0;
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s out[%0d]", tag, d), 64'(out_w[d]), 64'(0));
      chk($sformatf("%s valid[%0d]", tag, d), 64'(valid_w[d]), 64'(0));
      chk($sformatf("%s fe[%0d]", tag, d), 64'(fe_w[d]), 64'(0));
      chk($sformatf("%s ov[%0d]", tag, d), 64'(ov_w[d]), 64'(0));
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s out[%0d]", tag, d), 64'(out_w[d]), 64'(exp_out[d]));
      chk($sformatf("%s valid[%0d]", tag, d), 64'(valid_w[d]), 64'(exp_valid[d]));
      chk($sformatf("%s frame_err_cnt[%0d]", tag, d), 64'(fe_cnt[d]), 64'(exp_fe[d]));
      chk($sformatf("%s overrun_cnt[%0d]", tag, d), 64'(ov_cnt[d]), 64'(exp_ov[d]));
      chk($sformatf("%s accepted_n[%0d]", tag, d), 64'(acc_q[d].size()),
          64'(exp_acc[d].size()));
      for (int i = 0; i < exp_acc[d].size() && i < acc_q[d].size(); i++)
        chk($sformatf("%s accepted[%0d][%0d]", tag, d, i), 64'(acc_q[d][i]),
            64'(exp_acc[d][i]));
      acc_q[d].delete();
      exp_acc[d].delete();
    end
  endtask

  // Each bit: mosi set, leading sclk edge, trailing edge, 4 clk apart, so mosi
  // is stable across both edges and every mode samples the same bit.
  task automatic send_frame(input logic [63:0] tx, input int nbits, input bit lat_chk,
                            input bit rst_mid);
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      mosi = tx[k];
      repeat (4) @(negedge clk);
      sclk_base = 1'b1;
      if (lat_chk && k == W - 1) begin
        @(posedge clk);
        @(posedge clk);
        #1 chk("latency edge2 valid[0]", 64'(valid_w[0]), 64'(0));
        @(posedge clk);
        #1 chk("latency edge3 valid[0]", 64'(valid_w[0]), 64'(1));
        chk("latency edge3 out[0]", 64'(out_w[0]), 64'(tx[W-1:0]));
        @(negedge clk);
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk_base = 1'b0;
      repeat (4) @(negedge clk);
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("mid-frame reset");
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    logic [63:0] tx;
    int          nb;
    bit          r;

    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("after release");

    // 0xA5C3 LSB first; mode 0 latency checked against the 16th rising sclk edge.
    tx = 64'h0000_0000_0000_A5C3;
    send_frame(tx, 16, 1'b1, 1'b0);
    model_frame(tx, 16);
    check_all("a5c3");
    set_ready(1'b1);
    set_ready(1'b0);
    check_all("a5c3 consumed");

    // 0x1234 MSB first for modes 1..3.
    tx = 64'(rev(16'h1234));
    send_frame(tx, 16, 1'b0, 1'b0);
    model_frame(tx, 16);
    check_all("1234");
    chk("mode1 out", 64'(out_w[1]), 64'h1234);
    chk("mode3 out", 64'(out_w[3]), 64'h1234);
    set_ready(1'b1);

    // Back-to-back words in one frame with out_ready held high.
    tx = 64'h0000_0000_FF00_00FF;
    send_frame(tx, 32, 1'b0, 1'b0);
    model_frame(tx, 32);
    check_all("two words ready");
    set_ready(1'b0);

    // Two words with out_ready low: second word dropped, one overrun.
    tx = {32'h0, 16'($urandom), 16'($urandom)};
    send_frame(tx, 32, 1'b0, 1'b0);
    model_frame(tx, 32);
    check_all("two words overrun");
    set_ready(1'b1);
    set_ready(1'b0);

    // Truncated frame, then a clean 0xBEEF.
    tx = 64'($urandom);
    send_frame(tx, 7, 1'b0, 1'b0);
    model_frame(tx, 7);
    check_all("truncated");
    tx = 64'h0000_0000_0000_BEEF;
    send_frame(tx, 16, 1'b0, 1'b0);
    model_frame(tx, 16);
    check_all("beef");

    // Leave a word pending, then reset in the middle of the next frame.
    tx = 64'($urandom);
    send_frame(tx, 8, 1'b0, 1'b1);
    model_reset();
    check_all("after mid reset");
    tx = 64'h0000_0000_0000_5A5A;
    send_frame(tx, 16, 1'b0, 1'b0);
    model_frame(tx, 16);
    check_all("5a5a");

    for (int it = 0; it < 5; it++) begin
      r = 1'($urandom_range(0, 1));
      set_ready(r);
      nb = (it % 2 == 0) ? 16 * int'($urandom_range(1, 3)) : int'($urandom_range(3, 47));
      tx = {32'($urandom), 32'($urandom)};
      send_frame(tx, nb, 1'b0, 1'b0);
      model_frame(tx, nb);
      check_all($sformatf("random %0d", it));
    end
    set_ready(1'b1);
    set_ready(1'b0);
    check_all("final drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_rx_sync.md
SPI_RX_SYNC -- requirements
Module: spi_rx_sync

Interface
REQ-001 Parameter DATA_BITS, default 16, sets the word length; legal range 2..64.
REQ-002 Parameter CPOL, default 0, sets the SPI clock idle level.
REQ-003 Parameter CPHA, default 0, sets the SPI clock phase.
REQ-004 Parameter LSB_FIRST, default 1; 1 = first received bit lands in out[0], 0 = first bit lands in out[DATA_BITS-1].
REQ-005 Port clk, input, 1: system clock; one clock domain, rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port sclk, input, 1: SPI serial clock; asynchronous to clk.
REQ-008 Port mosi, input, 1: SPI serial data in; asynchronous to clk.
REQ-009 Port cs_n, input, 1: SPI chip select, active-low; asynchronous to clk.
REQ-010 Port out, output, DATA_BITS: last completed word.
REQ-011 Port out_valid, output, 1: out holds an unconsumed word.
REQ-012 Port out_ready, input, 1: consumer accepts out when out_valid && out_ready at a clk edge.
REQ-013 Port frame_err, output, 1: one-cycle pulse on a truncated word.
REQ-014 Port overrun, output, 1: one-cycle pulse on a dropped word.

Function
REQ-015 sclk, mosi and cs_n SHALL each pass through a 2-flop synchroniser, plus one history flop on sclk and cs_n for edge detection.
REQ-016 Sample edge SHALL be the synchronised sclk rising edge when CPOL==CPHA, and the falling edge otherwise.
REQ-017 The FSM SHALL have states IDLE and ACTIVE.
REQ-018 IDLE->ACTIVE SHALL occur on a synchronised cs_n falling edge and SHALL clear the bit counter and shift register.
REQ-019 ACTIVE->IDLE SHALL occur on a synchronised cs_n rising edge.
REQ-020 In ACTIVE, each sample edge SHALL shift the synchronised mosi into the shift register (direction per LSB_FIRST) and increment the bit counter.
REQ-021 Sample edges in IDLE SHALL be ignored.
REQ-022 When the counter reaches DATA_BITS, the module SHALL complete a word, reset the counter to 0 and stay in ACTIVE, so back-to-back words are received within one cs_n frame.
REQ-023 Word completion with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, SHALL load out on that edge and set out_valid=1.
REQ-024 Word completion with out_valid=1 and out_ready=0 SHALL leave out unchanged, drop the new word and pulse overrun for 1 cycle.
REQ-025 out_valid SHALL clear on out_valid && out_ready when no word completes in that cycle.
REQ-026 out SHALL hold its value at all other times.
REQ-027 Latency SHALL be: out/out_valid update on the 3rd rising clk edge after the raw final sample edge of sclk is first captured by clk.
REQ-028 A cs_n rising edge with bit counter !=0 SHALL pulse frame_err for 1 cycle and discard the partial word, leaving out and out_valid untouched.
REQ-029 A cs_n rising edge with bit counter ==0 SHALL produce no frame_err.
REQ-030 A sample edge and a cs_n rising edge in the same cycle: cs_n SHALL take priority and the edge SHALL be ignored.
REQ-031 The bench SHALL guarantee sclk high and low phases of >=3 clk periods and mosi stable across each sample edge; behaviour outside this limit is undefined.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, counter 0, shift register 0, out=0, out_valid=0, frame_err=0, overrun=0.
REQ-033 Synchroniser flops SHALL reset to the idle levels sclk=CPOL and cs_n=1, so that reset release never produces a spurious edge.
REQ-034 Reset asserted mid-frame SHALL abort the word, and the next word SHALL be received only after a fresh cs_n falling edge.

Verification
REQ-035 Mode 0, LSB_FIRST=1, DATA_BITS=16, send 0xA5C3 LSB first -> out=0xA5C3, out_valid=1 three clk edges after the 16th rising sclk edge.
REQ-036 Modes 1, 2 and 3 with LSB_FIRST=0, send 0x1234 -> out=0x1234 in each mode, sampled on the correct sclk edge.
REQ-037 One frame with 2 words 0x00FF and 0xFF00, out_ready held 1 -> two out_valid loads in order, no overrun.
REQ-038 Two words with out_ready held 0 -> out=first word, out_valid=1, overrun pulses once, second word lost.
REQ-039 cs_n raised after 7 bits -> frame_err pulses once, out unchanged; the next full frame with 0xBEEF yields out=0xBEEF.
REQ-040 rst_n pulsed low after 8 bits, then a full frame of 0x5A5A -> all outputs 0 during reset, then out=0x5A5A with no frame_err.
